// File: rtl/dc_ex_bundle_reg.sv
// Decode-to-execute pipeline register for the four-slot VLIW bundle
// (slot 0=ixu1, 1=ixu2, 2=lsu, 3=bru). Resolves memory freeze, branch
// flush and load-use bubbles, keeps bubble/flush counters and watches
// for a memory freeze that never ends.
//
// Hold handshake: dc_hold=1 means decode must present the same bundle
// again next cycle; dc_hold=0 means the bundle on dc_* is consumed (or
// deliberately dropped on a flush) at this rising edge.
module dc_ex_bundle_reg #(
    parameter int CTRL_W     = 32,
    parameter int CNT_W      = 16,
    parameter int FREEZE_MAX = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            dc_valid,
    input  logic [19:0]           dc_rd,
    input  logic [19:0]           dc_rs1,
    input  logic [19:0]           dc_rs2,
    input  logic [4*CTRL_W-1:0]   dc_ctrl,
    input  logic                  dc_lsu_is_load,
    input  logic                  hazard_stall,
    input  logic                  mem_stall,
    input  logic                  flush,
    output logic [3:0]            ex_valid,
    output logic [19:0]           ex_rd,
    output logic [19:0]           ex_rs1,
    output logic [19:0]           ex_rs2,
    output logic [4*CTRL_W-1:0]   ex_ctrl,
    output logic [4:0]            lsu_ex_rd,
    output logic                  lsu_ex_is_load,
    output logic                  dc_hold,
    output logic [CNT_W-1:0]      bubble_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic                  freeze_timeout
);

    localparam int FW = (FREEZE_MAX < 1) ? 1 : $clog2(FREEZE_MAX + 1);
    localparam logic [FW-1:0]    FRZ_MAX = FW'(FREEZE_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        WD_RUN    = 1'b0,
        WD_FREEZE = 1'b1
    } wd_state_t;

    wd_state_t      wd_state_q, wd_state_d;
    logic [FW-1:0]  frz_cnt_q;

    // Priority decode: freeze beats flush beats load-use bubble.
    logic do_freeze, do_flush, do_bubble, do_capture;
    assign do_freeze  = mem_stall;
    assign do_flush   = ~mem_stall & flush;
    assign do_bubble  = ~mem_stall & ~flush & hazard_stall;
    assign do_capture = ~mem_stall & ~flush & ~hazard_stall;

    // Only combinational in-to-out path; forced low while reset is asserted.
    assign dc_hold   = rst_n & (mem_stall | (hazard_stall & ~flush));

    // LSU slot destination fed back to hazard detection straight from the register.
    assign lsu_ex_rd = ex_rd[14:10];

    // EX-stage bundle registers: hold on freeze, zero on flush/bubble, else capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid       <= '0;
            ex_rd          <= '0;
            ex_rs1         <= '0;
            ex_rs2         <= '0;
            ex_ctrl        <= '0;
            lsu_ex_is_load <= 1'b0;
        end else if (do_flush || do_bubble) begin
            // ex_ctrl keeps its stale value; it is meaningless with ex_valid=0.
            ex_valid       <= '0;
            ex_rd          <= '0;
            ex_rs1         <= '0;
            ex_rs2         <= '0;
            lsu_ex_is_load <= 1'b0;
        end else if (do_capture) begin
            ex_valid       <= dc_valid;
            ex_rd          <= dc_rd;
            ex_rs1         <= dc_rs1;
            ex_rs2         <= dc_rs2;
            ex_ctrl        <= dc_ctrl;
            lsu_ex_is_load <= dc_lsu_is_load & dc_valid[2];
        end
    end

    // Saturating bubble and flush performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (do_bubble && bubble_cnt != CNT_MAX) bubble_cnt <= bubble_cnt + 1'b1;
            if (do_flush && flush_cnt != CNT_MAX)   flush_cnt  <= flush_cnt + 1'b1;
        end
    end

    // Watchdog state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wd_state_q <= WD_RUN;
        else        wd_state_q <= wd_state_d;
    end

    // Watchdog next state: frozen exactly while the memory reports busy.
    always_comb begin
        wd_state_d = wd_state_q;
        case (wd_state_q)
            WD_RUN:    if (do_freeze)  wd_state_d = WD_FREEZE;
            WD_FREEZE: if (!do_freeze) wd_state_d = WD_RUN;
            default:   wd_state_d = WD_RUN;
        endcase
    end

    // Freeze length counter (stall cycles already seen) and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frz_cnt_q      <= '0;
            freeze_timeout <= 1'b0;
        end else if (wd_state_d == WD_FREEZE) begin
            if (frz_cnt_q != FRZ_MAX) frz_cnt_q <= frz_cnt_q + 1'b1;
            if (frz_cnt_q == FRZ_MAX) freeze_timeout <= 1'b1;
        end else begin
            frz_cnt_q <= '0;
        end
    end

endmodule

// File: tb/tb_dc_ex_bundle_reg.sv
// Bench for dc_ex_bundle_reg: directed walk through the load-use, flush,
// freeze and saturation scenarios followed by randomized traffic, all
// checked every cycle against a behavioural model of the pipe register.
module tb_dc_ex_bundle_reg;

    localparam int CTRL_W     = 8;
    localparam int CNT_W      = 2;
    localparam int FREEZE_MAX = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]          dc_valid = '0;
    logic [19:0]         dc_rd = '0, dc_rs1 = '0, dc_rs2 = '0;
    logic [4*CTRL_W-1:0] dc_ctrl = '0;
    logic                dc_lsu_is_load = 1'b0;
    logic                hazard_stall = 1'b0, mem_stall = 1'b0, flush = 1'b0;

    logic [3:0]          ex_valid;
    logic [19:0]         ex_rd, ex_rs1, ex_rs2;
    logic [4*CTRL_W-1:0] ex_ctrl;
    logic [4:0]          lsu_ex_rd;
    logic                lsu_ex_is_load, dc_hold, freeze_timeout;
    logic [CNT_W-1:0]    bubble_cnt, flush_cnt;

    dc_ex_bundle_reg #(.CTRL_W(CTRL_W), .CNT_W(CNT_W), .FREEZE_MAX(FREEZE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .dc_valid(dc_valid), .dc_rd(dc_rd), .dc_rs1(dc_rs1), .dc_rs2(dc_rs2),
        .dc_ctrl(dc_ctrl), .dc_lsu_is_load(dc_lsu_is_load),
        .hazard_stall(hazard_stall), .mem_stall(mem_stall), .flush(flush),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_ctrl(ex_ctrl), .lsu_ex_rd(lsu_ex_rd), .lsu_ex_is_load(lsu_ex_is_load),
        .dc_hold(dc_hold), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt),
        .freeze_timeout(freeze_timeout)
    );

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A bundle is either frozen, dropped (flush/bubble) or copied across.
    logic [3:0]          m_valid;
    logic [19:0]         m_rd, m_rs1, m_rs2;
    logic [4*CTRL_W-1:0] m_ctrl;
    logic                m_load, m_to;
    int                  m_bub, m_fl, m_stall_run;

    task automatic model_clear_all();
        m_valid = '0; m_rd = '0; m_rs1 = '0; m_rs2 = '0; m_ctrl = '0;
        m_load = 1'b0; m_to = 1'b0; m_bub = 0; m_fl = 0; m_stall_run = 0;
    endtask

    task automatic model_drop();
        m_valid = '0; m_rd = '0; m_rs1 = '0; m_rs2 = '0; m_load = 1'b0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_clear_all();
        end else if (mem_stall) begin
            m_stall_run = m_stall_run + 1;
            if (m_stall_run > FREEZE_MAX) m_to = 1'b1;
        end else begin
            m_stall_run = 0;
            if (flush) begin
                model_drop();
                if (m_fl < CNT_MAX) m_fl = m_fl + 1;
            end else if (hazard_stall) begin
                model_drop();
                if (m_bub < CNT_MAX) m_bub = m_bub + 1;
            end else begin
                m_valid = dc_valid; m_rd = dc_rd; m_rs1 = dc_rs1; m_rs2 = dc_rs2;
                m_ctrl = dc_ctrl;
                m_load = dc_lsu_is_load && dc_valid[2];
            end
        end
    end

    // ---------------- compare process (mid-cycle) ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("ex_valid",       64'(ex_valid),       64'(m_valid));
            check("ex_rd",          64'(ex_rd),          64'(m_rd));
            check("ex_rs1",         64'(ex_rs1),         64'(m_rs1));
            check("ex_rs2",         64'(ex_rs2),         64'(m_rs2));
            check("ex_ctrl",        64'(ex_ctrl),        64'(m_ctrl));
            check("lsu_ex_rd",      64'(lsu_ex_rd),      64'((m_rd >> 10) & 20'h1f));
            check("lsu_ex_is_load", 64'(lsu_ex_is_load), 64'(m_load));
            check("bubble_cnt",     64'(bubble_cnt),     64'(m_bub));
            check("flush_cnt",      64'(flush_cnt),      64'(m_fl));
            check("freeze_timeout", 64'(freeze_timeout), 64'(m_to));
            check("dc_hold",        64'(dc_hold),
                  64'(rst_n && (mem_stall || (hazard_stall && !flush))));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ctl(input logic h, input logic m, input logic f);
        hazard_stall = h; mem_stall = m; flush = f;
    endtask

    task automatic drive_random_bundle();
        dc_valid       = 4'($urandom_range(0, 15));
        dc_rd          = 20'($urandom);
        dc_rs1         = 20'($urandom);
        dc_rs2         = 20'($urandom);
        dc_ctrl        = 32'($urandom);
        dc_lsu_is_load = 1'($urandom_range(0, 1));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        step();
        chk_en = 1'b1;
        repeat (2) step();
        check("lit_reset_valid", 64'(ex_valid), 64'h0);
        check("lit_reset_hold",  64'(dc_hold),  64'h0);

        // Reset then capture
        rst_n = 1'b1;
        dc_valid = 4'hF; dc_rd = 20'd7 << 10; dc_rs1 = 20'h12345; dc_rs2 = 20'h0abcd;
        dc_ctrl = 32'hdeadbeef; dc_lsu_is_load = 1'b1;
        step();
        check("lit_cap_valid", 64'(ex_valid),       64'hF);
        check("lit_cap_lsurd", 64'(lsu_ex_rd),      64'd7);
        check("lit_cap_load",  64'(lsu_ex_is_load), 64'd1);
        check("lit_cap_hold",  64'(dc_hold),        64'd0);

        // Load-use bubble, then the held bundle is captured
        drive_ctl(1, 0, 0);
        #1 check("lit_lu_hold", 64'(dc_hold), 64'd1);
        step();
        check("lit_lu_valid", 64'(ex_valid),       64'h0);
        check("lit_lu_load",  64'(lsu_ex_is_load), 64'd0);
        check("lit_lu_bub",   64'(bubble_cnt),     64'd1);
        drive_ctl(0, 0, 0);
        step();
        check("lit_lu_recap", 64'(ex_valid),       64'hF);
        check("lit_lu_rload", 64'(lsu_ex_is_load), 64'd1);

        // Flush together with a hazard stall
        drive_ctl(1, 0, 1);
        #1 check("lit_fl_hold", 64'(dc_hold), 64'd0);
        step();
        check("lit_fl_valid", 64'(ex_valid),   64'h0);
        check("lit_fl_cnt",   64'(flush_cnt),  64'd1);
        check("lit_fl_bub",   64'(bubble_cnt), 64'd1);
        drive_ctl(0, 0, 0);
        step();

        // Freeze beats flush; watchdog trips only after FREEZE_MAX+1 stall cycles
        drive_ctl(0, 1, 1);
        repeat (4) step();
        check("lit_fz_valid", 64'(ex_valid),       64'hF);
        check("lit_fz_hold",  64'(dc_hold),        64'd1);
        check("lit_fz_fl",    64'(flush_cnt),      64'd1);
        check("lit_fz_to4",   64'(freeze_timeout), 64'd0);
        step();
        check("lit_fz_to5",   64'(freeze_timeout), 64'd1);
        drive_ctl(0, 0, 0);
        repeat (3) step();
        check("lit_fz_sticky", 64'(freeze_timeout), 64'd1);

        // Saturation: five more bubbles land on 3
        drive_ctl(1, 0, 0);
        repeat (5) step();
        check("lit_sat_bub", 64'(bubble_cnt), 64'd3);

        // Asynchronous reset mid-stall clears immediately
        rst_n = 1'b0;
        #1 check("lit_arst_valid", 64'(ex_valid),       64'h0);
        check("lit_arst_to",       64'(freeze_timeout), 64'd0);
        check("lit_arst_hold",     64'(dc_hold),        64'd0);
        drive_ctl(0, 0, 0);
        step();
        rst_n = 1'b1;

        // Randomized traffic with bursty freezes and occasional resets
        for (int i = 0; i < 3000; i++) begin
            drive_random_bundle();
            if ($urandom_range(0, 99) < 3) begin
                mem_stall = ~mem_stall;
            end else if (mem_stall && $urandom_range(0, 99) < 15) begin
                mem_stall = 1'b0;
            end
            hazard_stall = ($urandom_range(0, 99) < 25);
            flush        = ($urandom_range(0, 99) < 12);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
